// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: forward selects, hazard FSM states, tracker slot
package pipe_pkg;

    localparam int PIPE_REG_W = 5;

    typedef logic [PIPE_REG_W-1:0] rw_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic v;
        rw_t  rw;
        logic wr;
        logic ld;
    } slot_t;

    // Register 0 is hardwired, so it can never be a hazard or forwarding source.
    function automatic logic slot_writes(slot_t s, rw_t r);
        return s.v && s.wr && (s.rw == r) && (r != '0);
    endfunction

    function automatic fwd_sel_t fwd_pick(slot_t mem_s, slot_t wb_s, rw_t r);
        if (slot_writes(mem_s, r) && !mem_s.ld)
            return FWD_MEM;
        else if (slot_writes(wb_s, r))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB destination tracker with hazard and forwarding compares
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             ex_kill,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_uses_rb,
    input  logic [REG_W-1:0] id_rw,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    output logic             ex_load_hit,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b
);

    slot_t ex_slot, mem_slot, wb_slot;
    rw_t   ex_ra, ex_rb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
            ex_ra    <= '0;
            ex_rb    <= '0;
        end else if (!hold) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (ex_kill) begin
                ex_slot <= '0;
                ex_ra   <= '0;
                ex_rb   <= '0;
            end else begin
                ex_slot <= '{v: id_valid, rw: rw_t'(id_rw), wr: id_reg_write, ld: id_is_load};
                ex_ra   <= rw_t'(id_ra);
                ex_rb   <= id_uses_rb ? rw_t'(id_rb) : '0;
            end
        end
    end

    assign ex_load_hit = id_valid && ex_slot.ld &&
                         (slot_writes(ex_slot, rw_t'(id_ra)) ||
                          (id_uses_rb && slot_writes(ex_slot, rw_t'(id_rb))));

    assign fwd_a = fwd_pick(mem_slot, wb_slot, ex_ra);
    assign fwd_b = fwd_pick(mem_slot, wb_slot, ex_rb);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush, memory hold and forwarding control
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_uses_rb,
    input  logic [REG_W-1:0] id_rw,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    hz_state_t state, next_state;
    logic      ex_load_hit;
    logic      sb_hold;
    logic      ex_kill;
    fwd_sel_t  sel_a, sel_b;

    hazard_scoreboard #(.REG_W(REG_W)) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (sb_hold),
        .ex_kill      (ex_kill),
        .id_valid     (id_valid),
        .id_ra        (id_ra),
        .id_rb        (id_rb),
        .id_uses_rb   (id_uses_rb),
        .id_rw        (id_rw),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .ex_load_hit  (ex_load_hit),
        .fwd_a        (sel_a),
        .fwd_b        (sel_b)
    );

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    // Priority: memory hold, then taken branch, then load-use. Reset forces the idle pattern.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        sb_hold     = 1'b0;
        ex_kill     = 1'b0;
        next_state  = ST_RUN;
        if (!rst_n) begin
            next_state = ST_RUN;
        end else if (mem_busy) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            sb_hold    = 1'b1;
            next_state = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            ex_kill     = 1'b1;
        end else if (ex_load_hit && state != ST_LOAD_STALL) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ex_kill     = 1'b1;
            next_state  = ST_LOAD_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            stall_count <= '0;
        end else begin
            state <= next_state;
            if (!pc_write && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed instruction sequences
module tb_hazard_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_ra = '0, id_rb = '0, id_rw = '0;
    logic        id_uses_rb = 1'b0, id_reg_write = 1'b0, id_is_load = 1'b0;
    logic        ex_branch_taken = 1'b0, mem_busy = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_hold;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_count;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_uses_rb(id_uses_rb), .id_rw(id_rw), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count)
    );

    hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
        .id_uses_rb(id_uses_rb), .id_rw(id_rw), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .pipe_hold(s_pipe_hold), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_count(s_stall_count)
    );

    typedef struct packed {
        logic [4:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
        logic [1:0]  sat;
    } exp_t;

    localparam logic [4:0] E_RUN = 5'b11000;
    localparam logic [4:0] E_LU  = 5'b00010;
    localparam logic [4:0] E_BR  = 5'b11110;
    localparam logic [4:0] E_HD  = 5'b00001;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_cnt = 0;

    function automatic logic [18:0] i_nop();
        return '0;
    endfunction
    function automatic logic [18:0] i_alu(logic [4:0] rw, logic [4:0] ra, logic [4:0] rb);
        return {1'b1, ra, rb, 1'b1, rw, 1'b1, 1'b0};
    endfunction
    function automatic logic [18:0] i_lw(logic [4:0] rw, logic [4:0] ra);
        return {1'b1, ra, 5'd0, 1'b0, rw, 1'b1, 1'b1};
    endfunction

    task automatic step(input string nm, input logic [18:0] ins, input logic br, input logic busy,
                        input logic rstv, input logic [4:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb);
        exp_t e;
        @(posedge clk);
        #1;
        {id_valid, id_ra, id_rb, id_uses_rb, id_rw, id_reg_write, id_is_load} = ins;
        ex_branch_taken = br;
        mem_busy = busy;
        rst_n = rstv;
        if (!rstv) exp_cnt = 0;
        e.ctl = ctl;
        e.fa  = fa;
        e.fb  = fb;
        e.cnt = 16'(exp_cnt);
        e.sat = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (rstv && !ctl[4]) exp_cnt++;
    endtask

    // Monitor: the DUT presents a full control word every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold};
            a.fa  = fwd_a;
            a.fb  = fwd_b;
            a.cnt = stall_count;
            a.sat = s_stall_count;
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b fa=%b fb=%b cnt=%0d sat=%0d, want ctl=%b fa=%b fb=%b cnt=%0d sat=%0d",
                         nm, a.ctl, a.fa, a.fb, a.cnt, a.sat, e.ctl, e.fa, e.fb, e.cnt, e.sat);
            end
        end
    end

    initial begin
        step("reset",        i_nop(), 0, 0, 0, E_RUN, 2'b00, 2'b00);
        step("post_reset",   i_nop(), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        // load-use
        step("lu_lw",        i_lw(5, 1),     0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("lu_stall",     i_alu(6, 5, 1), 0, 0, 1, E_LU,  2'b00, 2'b00);
        step("lu_resume",    i_alu(6, 5, 1), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("lu_fwd_wb",    i_nop(),        0, 0, 1, E_RUN, 2'b10, 2'b00);
        repeat (3) step("lu_drain", i_nop(), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        // ALU chain
        step("alu_add",      i_alu(3, 1, 2), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("alu_sub",      i_alu(4, 3, 3), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("alu_fwd_mem",  i_nop(),        0, 0, 1, E_RUN, 2'b01, 2'b01);
        repeat (2) step("alu_drain", i_nop(), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        // MEM over WB
        step("pri_add1",     i_alu(2, 1, 1), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("pri_add2",     i_alu(2, 3, 4), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("pri_or",       i_alu(7, 2, 0), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("pri_mem_wins", i_nop(),        0, 0, 1, E_RUN, 2'b01, 2'b00);
        repeat (2) step("pri_drain", i_nop(), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        // register 0
        step("r0_lw",        i_lw(0, 1),     0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("r0_no_stall",  i_alu(1, 0, 0), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("r0_no_fwd",    i_nop(),        0, 0, 1, E_RUN, 2'b00, 2'b00);
        repeat (2) step("r0_drain", i_nop(), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        // branch beats load-use
        step("br_lw",        i_lw(5, 1),     0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("br_flush",     i_alu(6, 5, 1), 1, 0, 1, E_BR,  2'b00, 2'b00);
        step("br_after",     i_nop(),        0, 0, 1, E_RUN, 2'b00, 2'b00);
        repeat (2) step("br_drain", i_nop(), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        // memory wait during load-use
        step("mw_lw",        i_lw(5, 1),     0, 0, 1, E_RUN, 2'b00, 2'b00);
        repeat (3) step("mw_hold", i_alu(6, 5, 1), 0, 1, 1, E_HD, 2'b00, 2'b00);
        step("mw_stall",     i_alu(6, 5, 1), 0, 0, 1, E_LU,  2'b00, 2'b00);
        step("mw_resume",    i_alu(6, 5, 1), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("mw_fwd_wb",    i_nop(),        0, 0, 1, E_RUN, 2'b10, 2'b00);
        step("mw_drain",     i_nop(),        0, 0, 1, E_RUN, 2'b00, 2'b00);
        // reset in the middle of a wait
        step("rw_lw",        i_lw(5, 1),     0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("rw_hold",      i_alu(6, 5, 1), 0, 1, 1, E_HD,  2'b00, 2'b00);
        step("rw_reset",     i_alu(6, 5, 1), 0, 1, 0, E_RUN, 2'b00, 2'b00);
        step("rw_release",   i_alu(6, 5, 1), 0, 0, 1, E_RUN, 2'b00, 2'b00);
        step("rw_clean",     i_nop(),        0, 0, 1, E_RUN, 2'b00, 2'b00);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
